// File: rtl/rr_pkg.sv
// rr_pkg: shared client enum, stale counter width and default payload width for the arbiter-side queue
package rr_pkg;
  typedef enum logic {CLIENT0, CLIENT1} client_e;
  localparam int STALE_W = 4;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/rr_fifo.sv
// rr_fifo: DEPTH-entry FIFO with separate occupancy count (clock, reset_n, push_valid/push_ready/push_data in, pop in, head/occ out)
module rr_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head,
  output logic [$clog2(DEPTH):0]  occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push;
  assign push_ready = occ < OW'(DEPTH);
  assign push = push_valid & push_ready;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      occ <= occ + OW'(push) - OW'(pop);
    end
endmodule

// File: rtl/rr_req_queue.sv
// rr_req_queue: two client FIFOs feeding a round-robin arbiter (ir/ack), registered pop channel (out_*), occupancies, stale-grant counters, sticky mutex_err
module rr_req_queue
  import rr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in0_valid,
  output logic                    in0_ready,
  input  logic [DATA_W-1:0]       in0_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  input  logic [DATA_W-1:0]       in1_data,
  output logic                    ir0,
  output logic                    ir1,
  input  logic                    ack0,
  input  logic                    ack1,
  output logic                    out_valid,
  output logic                    out_src,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]  occ0,
  output logic [$clog2(DEPTH):0]  occ1,
  output logic [STALE_W-1:0]      stale0,
  output logic [STALE_W-1:0]      stale1,
  output logic                    mutex_err
);
  logic [DATA_W-1:0] head0, head1;
  logic solo0, solo1, pop0, pop1;
  client_e src;
  assign ir0 = occ0 != '0;
  assign ir1 = occ1 != '0;
  assign solo0 = ack0 & ~ack1;
  assign solo1 = ack1 & ~ack0;
  assign pop0 = solo0 & ir0;
  assign pop1 = solo1 & ir1;
  assign out_src = src;
  rr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clock(clock), .reset_n(reset_n), .push_valid(in0_valid), .push_ready(in0_ready),
    .push_data(in0_data), .pop(pop0), .head(head0), .occ(occ0)
  );
  rr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clock(clock), .reset_n(reset_n), .push_valid(in1_valid), .push_ready(in1_ready),
    .push_data(in1_data), .pop(pop1), .head(head1), .occ(occ1)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      src <= CLIENT0;
      out_data <= '0;
      stale0 <= '0;
      stale1 <= '0;
      mutex_err <= 1'b0;
    end else begin
      out_valid <= pop0 | pop1;
      if (pop0 | pop1) begin
        src <= pop1 ? CLIENT1 : CLIENT0;
        out_data <= pop1 ? head1 : head0;
      end
      if (solo0 & ~ir0 & ~&stale0) stale0 <= stale0 + STALE_W'(1);
      if (solo1 & ~ir1 & ~&stale1) stale1 <= stale1 + STALE_W'(1);
      mutex_err <= mutex_err | (ack0 & ack1);
    end
endmodule

// File: tb/tb_rr_req_queue.sv
// tb_rr_req_queue: table vectors plus queue-based reference model and output scoreboard for rr_req_queue
module tb_rr_req_queue;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in0_valid = 1'b0, in1_valid = 1'b0, ack0 = 1'b0, ack1 = 1'b0;
  logic [7:0] in0_data = '0, in1_data = '0;
  logic in0_ready, in1_ready, ir0, ir1, out_valid, out_src, mutex_err;
  logic [7:0] out_data;
  logic [2:0] occ0, occ1;
  logic [3:0] stale0, stale1;
  int checks = 0;
  int failures = 0;
  logic [7:0] q0[$], q1[$];
  logic [8:0] sb[$];
  int m_st0 = 0, m_st1 = 0;
  logic m_mux = 1'b0, m_ov = 1'b0, m_src = 1'b0;
  logic [7:0] m_data = '0;
  typedef struct {
    logic v0; logic [7:0] d0; logic v1; logic [7:0] d1; logic a0; logic a1;
    logic [2:0] eocc0; logic [2:0] eocc1; logic eir0; logic [3:0] est0;
  } vec_t;
  vec_t vec[13];

  rr_req_queue dut (
    .clock(clock), .reset_n(reset_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .ir0(ir0), .ir1(ir1), .ack0(ack0), .ack1(ack1),
    .out_valid(out_valid), .out_src(out_src), .out_data(out_data),
    .occ0(occ0), .occ1(occ1), .stale0(stale0), .stale1(stale1), .mutex_err(mutex_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [8:0] e;
    chk("out_valid", out_valid, m_ov);
    if (out_valid) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        m_src = e[8];
        m_data = e[7:0];
      end
    end
    chk("out_src", out_src, m_src);
    chk("out_data", out_data, m_data);
    chk("occ0", occ0, q0.size());
    chk("occ1", occ1, q1.size());
    chk("ir0", ir0, q0.size() != 0);
    chk("ir1", ir1, q1.size() != 0);
    chk("in0_ready", in0_ready, q0.size() < 4);
    chk("in1_ready", in1_ready, q1.size() < 4);
    chk("stale0", stale0, m_st0);
    chk("stale1", stale1, m_st1);
    chk("mutex_err", mutex_err, m_mux);
  endtask

  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                      input logic a0, input logic a1);
    logic r0, r1, p0, p1;
    @(negedge clock);
    in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; ack0 = a0; ack1 = a1;
    @(posedge clock);
    r0 = q0.size() < 4;
    r1 = q1.size() < 4;
    p0 = a0 && !a1 && q0.size() != 0;
    p1 = a1 && !a0 && q1.size() != 0;
    if (a0 && !a1 && q0.size() == 0 && m_st0 < 15) m_st0++;
    if (a1 && !a0 && q1.size() == 0 && m_st1 < 15) m_st1++;
    if (a0 && a1) m_mux = 1'b1;
    if (p0) sb.push_back({1'b0, q0.pop_front()});
    if (p1) sb.push_back({1'b1, q1.pop_front()});
    if (v0 && r0) q0.push_back(d0);
    if (v1 && r1) q1.push_back(d1);
    m_ov = p0 | p1;
    #1 check_all();
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  initial begin
    vec[0]  = '{1, 8'hA1, 0, 8'h00, 0, 0, 1, 0, 1, 0};
    vec[1]  = '{1, 8'hA2, 0, 8'h00, 1, 0, 1, 0, 1, 0};
    vec[2]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 0};
    vec[3]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 1};
    vec[4]  = '{0, 8'h00, 1, 8'hB0, 0, 0, 0, 1, 0, 1};
    vec[5]  = '{0, 8'h00, 1, 8'hB1, 0, 0, 0, 2, 0, 1};
    vec[6]  = '{0, 8'h00, 1, 8'hB2, 0, 0, 0, 3, 0, 1};
    vec[7]  = '{0, 8'h00, 1, 8'hB3, 0, 0, 0, 4, 0, 1};
    vec[8]  = '{0, 8'h00, 1, 8'hB4, 0, 0, 0, 4, 0, 1};
    vec[9]  = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 3, 0, 1};
    vec[10] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 2, 0, 1};
    vec[11] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 1};
    vec[12] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 1};
    repeat (2) @(posedge clock);
    #1 check_all();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step(vec[i].v0, vec[i].d0, vec[i].v1, vec[i].d1, vec[i].a0, vec[i].a1);
      chk("tbl_occ0", occ0, vec[i].eocc0);
      chk("tbl_occ1", occ1, vec[i].eocc1);
      chk("tbl_ir0", ir0, vec[i].eir0);
      chk("tbl_stale0", stale0, vec[i].est0);
    end
    for (int i = 0; i < 3; i++) step(1, 8'h10 + 8'(i), 1, 8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 8'h00, 0, 1);
    end
    step(1, 8'h31, 1, 8'h41, 0, 0);
    step(0, 8'h00, 0, 8'h00, 1, 1);
    idle();
    idle();
    step(0, 8'h00, 0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 1);
    step(1, 8'h50, 0, 8'h00, 0, 0);
    step(1, 8'h51, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'h60 + 8'(i), 0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 8'h00, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i), 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 8'h00, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ir0", ir0, 0);
    chk("rst_occ0", occ0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stale0", stale0, 0);
    chk("rst_mutex", mutex_err, 0);
    q0.delete(); q1.delete(); sb.delete();
    m_st0 = 0; m_st1 = 0; m_mux = 1'b0; m_ov = 1'b0; m_src = 1'b0; m_data = '0;
    in0_valid = 1'b0; in1_valid = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 8'h55, 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 8'h00, 1, 0);
    chk("post_rst_data", out_data, 8'h55);
    idle();
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
